// File: rtl/uart_packer_fifo_top_if.sv
// Read-side bundle of the UART packer FIFO.
// Master drains words, slave is the FIFO.
interface uart_packer_fifo_top_if;
  logic         r_en;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         empty;
  logic         full;

  modport master (
    output r_en,
    input  rd_data, rd_valid, empty, full
  );

  modport slave (
    input  r_en,
    output rd_data, rd_valid, empty, full
  );
endinterface

// File: rtl/uart_packer_fifo_top.sv
// UART 8N1 receiver, 16-byte packer and 128-bit sync FIFO.
// Bytes land LSB-first in each packed word.
module uart_rx_stage #(
  parameter int TB_DATA_WIDTH = 8,
  parameter int TB_CLK_FREQ   = 100_000_000,
  parameter int TB_BAUD_RATE  = 115200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx,
  output logic                     o_done,
  output logic [TB_DATA_WIDTH-1:0] o_byte
);
  localparam int CPB = TB_CLK_FREQ / TB_BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = (TB_DATA_WIDTH > 1) ?
                       $clog2(TB_DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] BLST = BW'(TB_DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } rx_state_t;

  rx_state_t               r_state, w_state_n;
  logic [1:0]              r_sync;
  logic [CW-1:0]           r_cnt, w_cnt_n;
  logic [BW-1:0]           r_bit, w_bit_n;
  logic [TB_DATA_WIDTH-1:0] r_shift, w_shift_n;
  logic [TB_DATA_WIDTH-1:0] r_byte, w_byte_n;
  logic                    r_done, w_done_n;
  logic                    w_rx;

  assign w_rx   = r_sync[1];
  assign o_done = r_done;
  assign o_byte = r_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_byte  <= w_byte_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_byte_n  = r_byte;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_n = S_START;
          w_cnt_n   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          // high at mid-start means it was a glitch
          w_state_n = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_n   = '0;
          w_shift_n = {w_rx,
                       r_shift[TB_DATA_WIDTH-1:1]};
          if (r_bit == BLST) w_state_n = S_STOP;
          else               w_bit_n = r_bit + 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
          if (w_rx) begin
            w_done_n = 1'b1;
            w_byte_n = r_shift;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end
endmodule

module sync_fifo_stage #(
  parameter int TB_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_stb,
  input  logic [127:0]    i_wr_data,
  uart_packer_fifo_top_if.slave rd,
  output logic            o_overflow
);
  localparam int AW = $clog2(TB_DEPTH);

  logic [127:0] mem [TB_DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]  w_wr_n, w_rd_n;
  logic         r_empty, r_full, r_ovf;
  logic         r_rd_valid;
  logic [127:0] r_rd_data;
  logic         w_we, w_re;

  assign w_we   = i_wr_stb && !r_full;
  assign w_re   = rd.r_en && !r_empty;
  assign w_wr_n = r_wr_ptr + (AW+1)'(w_we);
  assign w_rd_n = r_rd_ptr + (AW+1)'(w_re);

  assign rd.rd_data  = r_rd_data;
  assign rd.rd_valid = r_rd_valid;
  assign rd.empty    = r_empty;
  assign rd.full     = r_full;
  assign o_overflow  = r_ovf;

  always_ff @(posedge clk) begin
    if (w_we) mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ptr   <= w_wr_n;
      r_rd_ptr   <= w_rd_n;
      r_empty    <= (w_wr_n == w_rd_n);
      // same index, opposite lap bit
      r_full     <= (w_wr_n[AW] != w_rd_n[AW]) &&
                    (w_wr_n[AW-1:0] == w_rd_n[AW-1:0]);
      r_rd_valid <= w_re;
      if (w_re) r_rd_data <= mem[r_rd_ptr[AW-1:0]];
      if (i_wr_stb && r_full) r_ovf <= 1'b1;
    end
  end
endmodule

module uart_packer_fifo_top #(
  parameter int TB_DATA_WIDTH = 8,
  parameter int TB_CLK_FREQ   = 100_000_000,
  parameter int TB_BAUD_RATE  = 115200,
  parameter int TB_DEPTH      = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  uart_packer_fifo_top_if.slave fifo_rd,
  output logic rx_done,
  output logic overflow
);
  logic [7:0]   w_rx_byte;
  logic         w_rx_done;
  logic [3:0]   r_pk_cnt;
  logic [127:0] r_pk_word;
  logic [127:0] r_wr_word;
  logic         r_wr_stb;

  assign rx_done = w_rx_done;

  uart_rx_stage #(
    .TB_DATA_WIDTH (TB_DATA_WIDTH),
    .TB_CLK_FREQ   (TB_CLK_FREQ),
    .TB_BAUD_RATE  (TB_BAUD_RATE)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_done (w_rx_done),
    .o_byte (w_rx_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pk_cnt  <= '0;
      r_pk_word <= '0;
      r_wr_word <= '0;
      r_wr_stb  <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_rx_done) begin
        r_pk_word[{r_pk_cnt, 3'b000} +: 8] <= w_rx_byte;
        r_pk_cnt <= r_pk_cnt + 1'b1;
        if (r_pk_cnt == 4'hF) begin
          r_wr_word <= {w_rx_byte, r_pk_word[119:0]};
          r_wr_stb  <= 1'b1;
        end
      end
    end
  end

  sync_fifo_stage #(
    .TB_DEPTH (TB_DEPTH)
  ) SYNC_FIFO_DUT (
    .clk        (clk),
    .rst        (rst),
    .i_wr_stb   (r_wr_stb),
    .i_wr_data  (r_wr_word),
    .rd         (fifo_rd),
    .o_overflow (overflow)
  );
endmodule

// File: tb/tb_uart_packer_fifo_top.sv
// Directed bench: two DUTs, one deep FIFO and one of depth 2.
// 16 clocks per bit keeps the run short.
module tb_uart_packer_fifo_top;
  localparam int FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int CPB  = FREQ / BAUD;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic rx_a, rx_b;
  logic done_a, done_b;
  logic ovf_a, ovf_b;

  int n_chk = 0;
  int n_err = 0;
  int n_done_a = 0;
  logic [7:0] last_a = '0;
  logic [127:0] rdq[$];

  uart_packer_fifo_top_if rd_a();
  uart_packer_fifo_top_if rd_b();

  uart_packer_fifo_top #(
    .TB_DATA_WIDTH (8),
    .TB_CLK_FREQ   (FREQ),
    .TB_BAUD_RATE  (BAUD),
    .TB_DEPTH      (16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst_a),
    .rx       (rx_a),
    .fifo_rd  (rd_a),
    .rx_done  (done_a),
    .overflow (ovf_a)
  );

  uart_packer_fifo_top #(
    .TB_DATA_WIDTH (8),
    .TB_CLK_FREQ   (FREQ),
    .TB_BAUD_RATE  (BAUD),
    .TB_DEPTH      (2)
  ) u_ovf (
    .clk      (clk),
    .rst      (rst_b),
    .rx       (rx_b),
    .fifo_rd  (rd_b),
    .rx_done  (done_b),
    .overflow (ovf_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_a) begin
      n_done_a = n_done_a + 1;
      last_a   = u_dut.w_rx_byte;
    end
    if (rd_a.rd_valid) rdq.push_back(rd_a.rd_data);
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_byte(input bit sel,
                           input logic [7:0] b);
    drive(sel, 1'b0);
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      idle(CPB);
    end
    drive(sel, 1'b1);
    idle(CPB);
  endtask

  int n0;
  logic [7:0] bv;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rd_a.r_en = 1'b0;
    rd_b.r_en = 1'b0;
    idle(5);
    chk("rst_empty",    128'(rd_a.empty),    128'd1);
    chk("rst_full",     128'(rd_a.full),     128'd0);
    chk("rst_rd_valid", 128'(rd_a.rd_valid), 128'd0);
    chk("rst_rd_data",  rd_a.rd_data,        128'd0);
    chk("rst_rx_done",  128'(done_a),        128'd0);
    chk("rst_overflow", 128'(ovf_a),         128'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(4);

    // single word
    for (int k = 0; k < 16; k++) send_byte(0, 8'hA0 + 8'(k));
    idle(20);
    chk("w0_done_cnt", 128'(n_done_a), 128'd16);
    chk("w0_mem0", u_dut.SYNC_FIFO_DUT.mem[0],
        128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    chk("w0_empty", 128'(rd_a.empty), 128'd0);

    // three more words
    for (int k = 0; k < 16; k++) begin
      bv = (k == 2) ? 8'hAB : 8'hB0 + 8'(k);
      send_byte(0, bv);
    end
    for (int k = 0; k < 16; k++) send_byte(0, 8'hC0 + 8'(k));
    for (int k = 0; k < 16; k++) send_byte(0, 8'hF0 + 8'(k));
    idle(20);
    chk("w4_done_cnt", 128'(n_done_a), 128'd64);
    chk("w4_mem1", u_dut.SYNC_FIFO_DUT.mem[1],
        128'hBFBEBDBCBBBAB9B8B7B6B5B4B3ABB1B0);
    chk("w4_mem2", u_dut.SYNC_FIFO_DUT.mem[2],
        128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
    chk("w4_mem3", u_dut.SYNC_FIFO_DUT.mem[3],
        128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    chk("w4_wr_ptr", 128'(u_dut.SYNC_FIFO_DUT.r_wr_ptr), 128'd4);
    chk("w4_full", 128'(rd_a.full), 128'd0);

    // drain with one extra read on empty
    rd_a.r_en = 1'b1;
    idle(5);
    rd_a.r_en = 1'b0;
    idle(3);
    chk("dr_count", 128'(rdq.size()), 128'd4);
    if (rdq.size() == 4) begin
      chk("dr_w0", rdq[0], 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
      chk("dr_w1", rdq[1], 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3ABB1B0);
      chk("dr_w2", rdq[2], 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
      chk("dr_w3", rdq[3], 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    end
    chk("dr_empty", 128'(rd_a.empty), 128'd1);
    chk("dr_hold", rd_a.rd_data,
        128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

    // short low pulse then a real byte
    n0 = n_done_a;
    rx_a = 1'b0;
    idle(CPB / 4);
    rx_a = 1'b1;
    idle(2 * CPB);
    send_byte(0, 8'h55);
    idle(20);
    chk("gl_done_cnt", 128'(n_done_a - n0), 128'd1);
    chk("gl_byte", 128'(last_a), 128'h55);

    // reset with a partial word pending
    for (int k = 0; k < 5; k++) send_byte(0, 8'h11 + 8'(k));
    idle(4);
    rst_a = 1'b1;
    idle(3);
    rst_a = 1'b0;
    idle(2);
    chk("rs_empty", 128'(rd_a.empty), 128'd1);
    chk("rs_rd_data", rd_a.rd_data, 128'd0);
    chk("rs_wr_ptr", 128'(u_dut.SYNC_FIFO_DUT.r_wr_ptr), 128'd0);
    chk("rs_rd_ptr", 128'(u_dut.SYNC_FIFO_DUT.r_rd_ptr), 128'd0);
    for (int k = 0; k < 16; k++) send_byte(0, 8'(k));
    idle(20);
    chk("rs_mem0", u_dut.SYNC_FIFO_DUT.mem[0],
        128'h0F0E0D0C0B0A09080706050403020100);
    chk("rs_wr_ptr1", 128'(u_dut.SYNC_FIFO_DUT.r_wr_ptr), 128'd1);
    chk("rs_empty0", 128'(rd_a.empty), 128'd0);

    // depth-2 FIFO overflow
    for (int k = 0; k < 32; k++) send_byte(1, 8'(k));
    idle(20);
    chk("ov_full", 128'(rd_b.full), 128'd1);
    chk("ov_pre", 128'(ovf_b), 128'd0);
    for (int k = 32; k < 48; k++) send_byte(1, 8'(k));
    idle(20);
    chk("ov_flag", 128'(ovf_b), 128'd1);
    chk("ov_mem0", u_ovf.SYNC_FIFO_DUT.mem[0],
        128'h0F0E0D0C0B0A09080706050403020100);
    chk("ov_mem1", u_ovf.SYNC_FIFO_DUT.mem[1],
        128'h1F1E1D1C1B1A19181716151413121110);
    chk("ov_wr_ptr", 128'(u_ovf.SYNC_FIFO_DUT.r_wr_ptr), 128'd2);
    idle(50);
    chk("ov_sticky", 128'(ovf_b), 128'd1);
    rst_b = 1'b1;
    idle(2);
    rst_b = 1'b0;
    idle(2);
    chk("ov_rst_flag", 128'(ovf_b), 128'd0);
    chk("ov_rst_full", 128'(rd_b.full), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
